data_memory_controller: RTL and testbench

//  Sequences and shares the single-port 16-bit data memory between two requesters:

---
 rtl/data_memory_controller.sv | 166 ++++++++++++++++
 tb/tb_data_memory_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_controller.sv
// data_memory_controller
// Arbitrates the single-port data memory between the pipeline memory stage (P)
// and the interrupt unit (I). I has fixed priority, and a granted access always runs to completion.
// Wide (2*DATA_W) accesses are split into two word beats: addr holds the high
// half and addr+1 the low half.
// Optional build macro: DMC_ADDR_CHECK_EN enables the beat address range check
// against MEM_DEPTH, with strobe suppression and an o_fault pulse.
module data_memory_controller #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_p_req,
    input  logic                  i_p_we,
    input  logic                  i_p_wide,
    input  logic [ADDR_W-1:0]     i_p_addr,
    input  logic [2*DATA_W-1:0]   i_p_wdata,
    output logic                  o_p_done,
    output logic                  o_p_stall,
    input  logic                  i_i_req,
    input  logic                  i_i_we,
    input  logic                  i_i_wide,
    input  logic [ADDR_W-1:0]     i_i_addr,
    input  logic [2*DATA_W-1:0]   i_i_wdata,
    output logic                  o_i_done,
    output logic                  o_i_stall,
    output logic [2*DATA_W-1:0]   o_rdata,
    output logic [ADDR_W-1:0]     o_mem_address,
    output logic [DATA_W-1:0]     o_mem_write_data,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    input  logic [DATA_W-1:0]     i_mem_read_data,
    output logic                  o_fault
);

    // A depth larger than the address space cannot be addressed.
    if (64'(MEM_DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
        $error("MEM_DEPTH exceeds the address space");
    end

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t                state;
    logic                  owner_i;
    logic                  we_q;
    logic                  wide_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]     word0;
    logic [DATA_W-1:0]     word1;
    logic                  p_done_q;
    logic                  i_done_q;
    logic [2*DATA_W-1:0]   rdata_q;

    logic                  beat_active;
    logic [ADDR_W-1:0]     beat_addr;
    logic                  addr_ok;
    logic [DATA_W-1:0]     beat_rdata;

    // Beat decode: address, range check and gated read data for the current beat.
    always_comb begin
        beat_active = (state == BEAT0) || (state == BEAT1);
        beat_addr   = (state == BEAT1) ? addr_q + ADDR_W'(1) : addr_q;
`ifdef DMC_ADDR_CHECK_EN
        addr_ok     = ({1'b0, beat_addr} < (ADDR_W+1)'(MEM_DEPTH));
`else
        addr_ok     = 1'b1;
`endif
        beat_rdata  = addr_ok ? i_mem_read_data : '0;
    end

    // Memory-side strobes, address and write data, decoded from state and latched regs only.
    always_comb begin
        o_mem_address    = beat_active ? beat_addr : '0;
        o_mem_read       = beat_active & ~we_q & addr_ok;
        o_mem_write      = beat_active &  we_q & addr_ok;
        o_mem_write_data = '0;
        if (beat_active) begin
            o_mem_write_data = ((state == BEAT0) && wide_q) ? wdata_q[2*DATA_W-1:DATA_W]
                                                            : wdata_q[DATA_W-1:0];
        end
`ifdef DMC_ADDR_CHECK_EN
        o_fault          = beat_active & ~addr_ok;
`else
        o_fault          = 1'b0;
`endif
    end

    // Requester-side outputs.
    always_comb begin
        o_p_done  = p_done_q;
        o_i_done  = i_done_q;
        o_rdata   = rdata_q;
        o_p_stall = i_p_req & ~p_done_q;
        o_i_stall = i_i_req & ~i_done_q;
    end

    // Arbitration and beat sequencing.
    // done and rdata are registered on entry to RESP, so they are high only in that state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            owner_i  <= 1'b0;
            we_q     <= 1'b0;
            wide_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word0    <= '0;
            word1    <= '0;
            p_done_q <= 1'b0;
            i_done_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            p_done_q <= 1'b0;
            i_done_q <= 1'b0;
            rdata_q  <= '0;
            case (state)
                IDLE: begin
                    if (i_i_req) begin
                        owner_i <= 1'b1;
                        we_q    <= i_i_we;
                        wide_q  <= i_i_wide;
                        addr_q  <= i_i_addr;
                        wdata_q <= i_i_wdata;
                        state   <= BEAT0;
                    end else if (i_p_req) begin
                        owner_i <= 1'b0;
                        we_q    <= i_p_we;
                        wide_q  <= i_p_wide;
                        addr_q  <= i_p_addr;
                        wdata_q <= i_p_wdata;
                        state   <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (!we_q) begin
                        word0 <= beat_rdata;
                    end
                    if (wide_q) begin
                        state <= BEAT1;
                    end else begin
                        state    <= RESP;
                        p_done_q <= ~owner_i;
                        i_done_q <= owner_i;
                        rdata_q  <= {{DATA_W{1'b0}}, (we_q ? word0 : beat_rdata)};
                    end
                end
                BEAT1: begin
                    if (!we_q) begin
                        word1 <= beat_rdata;
                    end
                    state    <= RESP;
                    p_done_q <= ~owner_i;
                    i_done_q <= owner_i;
                    rdata_q  <= {word0, (we_q ? word1 : beat_rdata)};
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// tb_data_memory_controller
// Directed scenarios with hand-computed expectations. It uses a behavioural 64K-word
// memory that writes at negedge and reads combinationally.
module tb_data_memory_controller;

    logic        clk;
    logic        rst_n;
    logic        p_req, p_we, p_wide;
    logic [15:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_done, p_stall;
    logic        i_req, i_we, i_wide;
    logic [15:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_done, i_stall;
    logic [31:0] rdata;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_rdata;
    logic        fault;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int passed = 0;

    data_memory_controller #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(4096)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p_req(p_req), .i_p_we(p_we), .i_p_wide(p_wide), .i_p_addr(p_addr),
        .i_p_wdata(p_wdata), .o_p_done(p_done), .o_p_stall(p_stall),
        .i_i_req(i_req), .i_i_we(i_we), .i_i_wide(i_wide), .i_i_addr(i_addr),
        .i_i_wdata(i_wdata), .o_i_done(i_done), .o_i_stall(i_stall),
        .o_rdata(rdata), .o_mem_address(mem_address), .o_mem_write_data(mem_wdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .i_mem_read_data(mem_rdata),
        .o_fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem[mem_address] : 16'h0000;

    // Drives one P transaction; it starts and ends 1 time unit after a posedge.
    task automatic run_p(input logic we, input logic wide, input logic [15:0] addr,
                         input logic [31:0] wd, output int done_cyc,
                         output logic [31:0] rd, output int wr_cyc);
        p_req = 1'b1; p_we = we; p_wide = wide; p_addr = addr; p_wdata = wd;
        done_cyc = -1; wr_cyc = 0; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_write) wr_cyc++;
            if (p_done) begin
                done_cyc = c;
                rd = rdata;
                break;
            end
        end
        @(posedge clk); #1;
        p_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({p_done, i_done} !== 2'b00) $display("FAIL reset_done got=%b exp=00", {p_done, i_done}); else passed++;
        checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", rdata); else passed++;
        checks++; if ({mem_read, mem_write, fault} !== 3'b000) $display("FAIL reset_strobes got=%b exp=000", {mem_read, mem_write, fault}); else passed++;
        checks++; if (mem_address !== 16'h0) $display("FAIL reset_addr got=%h exp=0000", mem_address); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_narrow();
        int dc, wc;
        logic [31:0] rd;
        run_p(1'b1, 1'b0, 16'h0010, 32'h0000_0A00, dc, rd, wc);
        checks++; if (dc !== 3) $display("FAIL narrow_wr_latency got=%0d exp=3", dc); else passed++;
        checks++; if (wc !== 1) $display("FAIL narrow_wr_strobe_cycles got=%0d exp=1", wc); else passed++;
        checks++; if (mem[16'h0010] !== 16'h0A00) $display("FAIL narrow_wr_mem got=%h exp=0a00", mem[16'h0010]); else passed++;
        // stall follows req before the grant completes
        p_req = 1'b1; p_we = 1'b0; p_wide = 1'b0; p_addr = 16'h0010;
        #1;
        checks++; if (p_stall !== 1'b1) $display("FAIL narrow_stall got=%b exp=1", p_stall); else passed++;
        run_p(1'b0, 1'b0, 16'h0010, 32'h0, dc, rd, wc);
        checks++; if (dc !== 3) $display("FAIL narrow_rd_latency got=%0d exp=3", dc); else passed++;
        checks++; if (rd !== 32'h0000_0A00) $display("FAIL narrow_rd_data got=%h exp=00000a00", rd); else passed++;
    endtask

    task automatic test_wide();
        int dc, wc;
        logic [31:0] rd;
        run_p(1'b1, 1'b1, 16'h0100, 32'h1234_5678, dc, rd, wc);
        checks++; if (dc !== 4) $display("FAIL wide_wr_latency got=%0d exp=4", dc); else passed++;
        checks++; if (wc !== 2) $display("FAIL wide_wr_strobe_cycles got=%0d exp=2", wc); else passed++;
        checks++; if (mem[16'h0100] !== 16'h1234) $display("FAIL wide_wr_hi got=%h exp=1234", mem[16'h0100]); else passed++;
        checks++; if (mem[16'h0101] !== 16'h5678) $display("FAIL wide_wr_lo got=%h exp=5678", mem[16'h0101]); else passed++;
        run_p(1'b0, 1'b1, 16'h0100, 32'h0, dc, rd, wc);
        checks++; if (dc !== 4) $display("FAIL wide_rd_latency got=%0d exp=4", dc); else passed++;
        checks++; if (rd !== 32'h1234_5678) $display("FAIL wide_rd_data got=%h exp=12345678", rd); else passed++;
    endtask

    task automatic test_priority();
        int dc, wc, i_cyc, p_cyc, stall_bad;
        logic [31:0] rd, i_rd, p_rd;
        logic [15:0] addr2;
        run_p(1'b1, 1'b0, 16'h0020, 32'h0000_BEEF, dc, rd, wc);
        p_req = 1'b1; p_we = 1'b0; p_wide = 1'b1; p_addr = 16'h0100; p_wdata = '0;
        i_req = 1'b1; i_we = 1'b0; i_wide = 1'b0; i_addr = 16'h0020; i_wdata = '0;
        i_cyc = -1; p_cyc = -1; stall_bad = 0; addr2 = '0; i_rd = '0; p_rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) addr2 = mem_address;
            if (i_done && i_cyc < 0) begin
                i_cyc = c;
                i_rd = rdata;
            end
            if (p_done) begin
                p_cyc = c;
                p_rd = rdata;
            end else if (p_stall !== 1'b1) begin
                stall_bad++;
            end
            @(posedge clk); #1;
            if (i_cyc > 0) i_req = 1'b0;
            if (p_cyc > 0) break;
        end
        p_req = 1'b0; i_req = 1'b0;
        checks++; if (addr2 !== 16'h0020) $display("FAIL prio_first_grant_addr got=%h exp=0020", addr2); else passed++;
        checks++; if (i_cyc !== 3) $display("FAIL prio_i_latency got=%0d exp=3", i_cyc); else passed++;
        checks++; if (i_rd !== 32'h0000_BEEF) $display("FAIL prio_i_data got=%h exp=0000beef", i_rd); else passed++;
        checks++; if (p_cyc !== 7) $display("FAIL prio_p_latency got=%0d exp=7", p_cyc); else passed++;
        checks++; if (p_rd !== 32'h1234_5678) $display("FAIL prio_p_data got=%h exp=12345678", p_rd); else passed++;
        checks++; if (stall_bad !== 0) $display("FAIL prio_p_stall_drops got=%0d exp=0", stall_bad); else passed++;
    endtask

    task automatic test_wrap();
        int dc, wc, faults;
        logic [15:0] a0, a1;
        p_req = 1'b1; p_we = 1'b1; p_wide = 1'b1; p_addr = 16'hFFFF; p_wdata = 32'hAAAA_BBBB;
        a0 = '0; a1 = '0; dc = -1; faults = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) a0 = mem_address;
            if (c == 3) a1 = mem_address;
            if (fault) faults++;
            if (p_done) begin
                dc = c;
                break;
            end
        end
        @(posedge clk); #1;
        p_req = 1'b0;
        checks++; if (dc !== 4) $display("FAIL wrap_latency got=%0d exp=4", dc); else passed++;
        checks++; if (a0 !== 16'hFFFF) $display("FAIL wrap_beat0_addr got=%h exp=ffff", a0); else passed++;
        checks++; if (a1 !== 16'h0000) $display("FAIL wrap_beat1_addr got=%h exp=0000", a1); else passed++;
        checks++; if (mem[16'h0000] !== 16'hBBBB) $display("FAIL wrap_mem0 got=%h exp=bbbb", mem[16'h0000]); else passed++;
`ifdef DMC_ADDR_CHECK_EN
        checks++; if (faults !== 1) $display("FAIL wrap_fault_cycles got=%0d exp=1", faults); else passed++;
`else
        checks++; if (faults !== 0) $display("FAIL wrap_fault_cycles got=%0d exp=0", faults); else passed++;
        checks++; if (mem[16'hFFFF] !== 16'hAAAA) $display("FAIL wrap_memffff got=%h exp=aaaa", mem[16'hFFFF]); else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        int dc, wc, dones, writes;
        logic [31:0] rd;
        run_p(1'b1, 1'b0, 16'h0201, 32'h0000_5555, dc, rd, wc);
        p_req = 1'b1; p_we = 1'b1; p_wide = 1'b1; p_addr = 16'h0200; p_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({mem_write, mem_address} !== {1'b1, 16'h0200}) $display("FAIL rstmid_beat0 got=%b/%h exp=1/0200", mem_write, mem_address); else passed++;
        @(posedge clk); #1;
        p_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_read, mem_write, mem_address, mem_wdata} !== 34'h0) $display("FAIL rstmid_idle_strobes got=%b%b/%h/%h exp=00/0000/0000", mem_read, mem_write, mem_address, mem_wdata); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0; writes = 0;
        repeat (5) begin
            @(negedge clk);
            if (p_done || i_done) dones++;
            if (mem_write) writes++;
        end
        @(posedge clk); #1;
        checks++; if (dones !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", dones); else passed++;
        checks++; if (writes !== 0) $display("FAIL rstmid_no_beats got=%0d exp=0", writes); else passed++;
        checks++; if (mem[16'h0200] !== 16'hCAFE) $display("FAIL rstmid_mem200 got=%h exp=cafe", mem[16'h0200]); else passed++;
        checks++; if (mem[16'h0201] !== 16'h5555) $display("FAIL rstmid_mem201 got=%h exp=5555", mem[16'h0201]); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        p_req = 1'b0; p_we = 1'b0; p_wide = 1'b0; p_addr = '0; p_wdata = '0;
        i_req = 1'b0; i_we = 1'b0; i_wide = 1'b0; i_addr = '0; i_wdata = '0;
        test_reset();
        test_narrow();
        test_wide();
        test_priority();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
